// File: rtl/lock_pkg.sv
// Shared constants for the lock front end: button count, event code width,
// button codes and the default debounce divider for a 125 MHz clock.
package lock_pkg;
  localparam int N_BTN         = 4;
  localparam int CODE_W        = $clog2(N_BTN);
  localparam int BTN_0         = 0;
  localparam int BTN_1         = 1;
  localparam int BTN_2         = 2;
  localparam int BTN_3         = 3;
  localparam int TICK_DIV_125M = 125000;
endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through event queue; push and pop together are legal even
// when full, so the arbiter can refill the slot being drained.
module sync_fifo #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr, r_rd;
  logic [AW:0]                 r_cnt;
  logic                        w_do_push, w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/btn_event_arbiter.sv
// Debounces raw lock buttons on a slow sample tick, qualifies presses, and
// round-robin queues one button code per transfer toward the lock FSM.
module btn_event_arbiter #(
  parameter  int N_BTN      = lock_pkg::N_BTN,
  parameter  int TICK_DIV   = lock_pkg::TICK_DIV_125M,
  parameter  int FIFO_DEPTH = 4,
  localparam int CODE_W     = $clog2(N_BTN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_in,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  input  logic              ev_ready,
  output logic              ev_overflow,
  output logic              tick
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]       r_tick_cnt;
  logic [N_BTN-1:0]       r_sync1, r_sync2;
  logic [N_BTN-1:0][2:0]  r_hist;
  logic [N_BTN-1:0]       r_pend;
  logic [CODE_W-1:0]      r_rr_ptr;
  logic                   r_ovf;

  logic                   w_tick;
  logic [N_BTN-1:0]       w_press, w_clr;
  logic                   w_gnt_vld, w_can_push, w_pop, w_full, w_empty;
  logic [CODE_W-1:0]      w_gnt_idx, w_head;

  assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV-1));
  assign tick   = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Buttons are asynchronous to clk: two flops before the history sampler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      if (w_tick)
        for (int i = 0; i < N_BTN; i++) r_hist[i] <= {r_hist[i][1:0], r_sync2[i]};
    end
  end

  always_comb begin
    w_press = '0;
    for (int i = 0; i < N_BTN; i++)
      w_press[i] = w_tick && ({r_hist[i][1:0], r_sync2[i]} == 3'b011);
  end

  assign w_pop      = !w_empty && ev_ready;
  assign w_can_push = !w_full || w_pop;

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (w_can_push)
      for (int k = N_BTN-1; k >= 0; k--)
        if (r_pend[(int'(r_rr_ptr) + k) % N_BTN]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CODE_W'((int'(r_rr_ptr) + k) % N_BTN);
        end
  end

  assign w_clr = w_gnt_vld ? (N_BTN'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_rr_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_press;
      r_ovf  <= |(w_press & r_pend & ~w_clr);
      if (w_gnt_vld)
        r_rr_ptr <= (w_gnt_idx == CODE_W'(N_BTN-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  sync_fifo #(.WIDTH(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_gnt_vld),
    .i_din   (w_gnt_idx),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign ev_valid    = !w_empty;
  assign ev_code     = ev_valid ? w_head : '0;
  assign ev_overflow = r_ovf;
endmodule
